spi_slave_burst: RTL and testbench
==================================

SPI_SLAVE_BURST -- requirements
Module: spi_slave_burst

Interface
REQ-001 SHALL have parameter CMD_W, default 8, command field width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address field width in bits.
REQ-003 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-004 SHALL have parameters WR_CMD and RD_CMD, defaults 8'h0A and 8'h0F, the write and read opcodes.
REQ-005 SHALL have parameter ADDR_INC, default 1, the address increment applied per burst word.
REQ-006 SHALL have port clk_100m, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n_syn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have ports sclk, cs_n and mosi, inputs, 1 bit each: SPI mode 0 bus, asynchronous to clk_100m.
REQ-009 SHALL have port miso, output, 1 bit: serial data to the master.
REQ-010 SHALL have ports wr_addr (ADDR_W), wr_data (DATA_W) and wr_stb (1), outputs: write word, address and one-cycle strobe.
REQ-011 SHALL have ports rd_addr (ADDR_W) and rd_req (1), outputs: read address and one-cycle request.
REQ-012 SHALL have ports rd_data (DATA_W) and rd_vld (1), inputs: read return data and its qualifier.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is active.
REQ-014 SHALL have ports err_cmd and err_underrun, outputs, 1 bit each: one-cycle error pulses.
REQ-015 SHALL have port word_cnt, output, 8 bits: count of completed data words in the current frame, saturating at 255.

Function
REQ-016 SHALL synchronise sclk, cs_n and mosi through two flip-flops each, and detect sclk rising and falling edges from the synchronised copy.
REQ-017 SHALL sample mosi MSB-first on each rising sclk edge, and update miso on each falling sclk edge only.
REQ-018 SHALL use the FSM states IDLE, CMD, ADDR, WR_DATA, RD_DATA and DISCARD.
REQ-019 SHALL leave IDLE for CMD when synchronised cs_n goes low.
REQ-020 SHALL, after CMD_W bits, go to ADDR if the opcode is WR_CMD or RD_CMD; otherwise it SHALL pulse err_cmd once and go to DISCARD.
REQ-021 SHALL, after ADDR_W bits, latch the base address and go to WR_DATA for WR_CMD or to RD_DATA for RD_CMD.
REQ-022 SHALL hold miso at 1 in DISCARD and ignore all further bits until cs_n goes high.
REQ-023 SHALL, in WR_DATA, for each DATA_W bits received, assert wr_stb for one cycle on the clk_100m cycle after the edge-detect of the final rising edge.
REQ-024 SHALL present with each wr_stb wr_data equal to the word received and wr_addr equal to base + n*ADDR_INC, where n counts words from 0.
REQ-025 SHALL, in RD_DATA, pulse rd_req with rd_addr = base on the final address rising edge.
REQ-026 SHALL capture the first read word on rd_vld, which must arrive before the next falling sclk edge, and drive its MSB on that falling edge.
REQ-027 SHALL prefetch each following word: it SHALL pulse rd_req for base + (n+1)*ADDR_INC on the falling edge that launches the MSB of word n, and hold the returned data in a one-word buffer.
REQ-028 SHALL, if no valid data is held when a word's MSB must launch, transmit that word as all ones and pulse err_underrun once.
REQ-029 SHALL ignore rd_vld that arrives with no outstanding request.
REQ-030 SHALL continue a burst while cs_n stays low, with no upper limit on word count.
REQ-031 SHALL wrap addresses modulo 2^ADDR_W.
REQ-032 SHALL increment word_cnt once per completed data word.
REQ-033 SHALL, when cs_n goes high in any state, go to IDLE within 1 cycle of the synchronised change.
REQ-034 SHALL, on that cs_n abort, discard any partial word (no wr_stb), drive miso to 1, clear the outstanding-request flag and reset word_cnt to 0 on the next frame start.
REQ-035 SHALL, if an sclk rising edge and a synchronised cs_n rise occur in the same cycle, give the cs_n rise priority.
REQ-036 SHALL hold busy high in every state except IDLE.

Reset
REQ-037 SHALL, while rst_n_syn is low, immediately put the FSM in IDLE and set miso=1, wr_stb=0, rd_req=0, busy=0, err_cmd=0, err_underrun=0, word_cnt=0, wr_addr=0, wr_data=0, rd_addr=0, with all synchroniser flops at 1 for cs_n and 0 for the others.
REQ-038 SHALL, after reset releases in the middle of a frame, ignore the rest of that frame until cs_n has been seen high.

Verification
REQ-039 Write of 1 word: 0A, addr 0x0010, data 0xDEADBEEF -> one wr_stb with wr_addr=0x0010 and wr_data=0xDEADBEEF, then word_cnt=1.
REQ-040 Write burst of 3 words at addr 0xFFFF -> wr_addr sequence 0xFFFF, 0x0000, 0x0001 (wrap).
REQ-041 Read burst: 0F, addr 0x0100, rd_vld one cycle after each rd_req -> rd_req for 0x0100, 0x0101, 0x0102; miso streams the returned words MSB-first.
REQ-042 Read with rd_vld withheld for word 1 -> word 1 on miso is 0xFFFFFFFF, with a single err_underrun pulse.
REQ-043 Opcode 0x55 -> one err_cmd pulse, miso held at 1, no wr_stb or rd_req until cs_n goes high.
REQ-044 cs_n raised after 17 data bits of a write -> no wr_stb; the next frame works normally.

Source files
------------

// File: rtl/spi_slave_burst.sv
// SPI mode-0 slave that turns command/address/data frames into bursts of
// register writes and prefetched reads on the clk_100m domain.
//
// state   | meaning
// IDLE    | no frame, waiting for a fresh cs_n fall
// CMD     | shifting in the opcode
// ADDR    | shifting in the burst base address
// WR_DATA | receiving write words, one wr_stb per word
// RD_DATA | launching read words on miso, prefetching the next word
// DISCARD | bad opcode, ignore the rest of the frame
module spi_slave_burst #(
  parameter int               CMD_W    = 8,
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 32,
  parameter logic [CMD_W-1:0] WR_CMD   = 8'h0A,
  parameter logic [CMD_W-1:0] RD_CMD   = 8'h0F,
  parameter int               ADDR_INC = 1
) (
  input  logic              clk_100m,
  input  logic              rst_n_syn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_vld,
  output logic              busy,
  output logic              err_cmd,
  output logic              err_underrun,
  output logic [7:0]        word_cnt
);

  localparam int SH_W = (DATA_W > ADDR_W) ? ((DATA_W > CMD_W) ? DATA_W : CMD_W)
                                          : ((ADDR_W > CMD_W) ? ADDR_W : CMD_W);
  localparam int CNT_W = $clog2(SH_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, DISCARD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        sclk_s, cs_s, mosi_s;
  logic              sclk_q;
  logic              sclk_sync, cs_sync, mosi_sync, sclk_rise, sclk_fall;
  logic [1:0]        fill;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt, tx_cnt;
  logic [SH_W-1:0]   rx_sh, rx_next;
  logic              is_rd;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] tx_sh, rbuf;
  logic              rbuf_vld, pending;
  logic              abort, cmd_last, addr_last, data_last, launch, op_wr, op_rd;

  assign sclk_sync = sclk_s[1];
  assign cs_sync   = cs_s[1];
  assign mosi_sync = mosi_s[1];
  assign sclk_rise = sclk_sync & ~sclk_q;
  assign sclk_fall = ~sclk_sync & sclk_q;
  assign busy      = (state != IDLE);

  // armed only goes high once cs_n has truly been seen high after reset,
  // so a frame already in progress at reset release is ignored
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      sclk_s <= 2'b00;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sclk_q <= 1'b0;
      fill   <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      cs_s   <= {cs_s[0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
      sclk_q <= sclk_sync;
      if (fill != 2'd3) fill <= fill + 2'd1;
      if (fill == 2'd3 && cs_sync) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    cmd_last  = 1'b0;
    addr_last = 1'b0;
    data_last = 1'b0;
    launch    = 1'b0;
    rx_next   = {rx_sh[SH_W-2:0], mosi_sync};
    op_wr     = (rx_next[CMD_W-1:0] == WR_CMD);
    op_rd     = (rx_next[CMD_W-1:0] == RD_CMD);
    // cs_n rising wins over any sclk edge seen in the same cycle
    if (state != IDLE && cs_sync) begin
      abort     = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (armed && !cs_sync) state_nxt = CMD;
        CMD:     if (sclk_rise && bit_cnt == CNT_W'(CMD_W - 1)) begin
                   cmd_last  = 1'b1;
                   state_nxt = (op_wr || op_rd) ? ADDR : DISCARD;
                 end
        ADDR:    if (sclk_rise && bit_cnt == CNT_W'(ADDR_W - 1)) begin
                   addr_last = 1'b1;
                   state_nxt = is_rd ? RD_DATA : WR_DATA;
                 end
        WR_DATA: data_last = sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));
        RD_DATA: begin
                   data_last = sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));
                   launch    = sclk_fall && (tx_cnt == '0);
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      miso         <= 1'b1;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_stb       <= 1'b0;
      rd_addr      <= '0;
      rd_req       <= 1'b0;
      err_cmd      <= 1'b0;
      err_underrun <= 1'b0;
      word_cnt     <= 8'd0;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_sh        <= '0;
      is_rd        <= 1'b0;
      ptr          <= '0;
      tx_sh        <= '1;
      rbuf         <= '0;
      rbuf_vld     <= 1'b0;
      pending      <= 1'b0;
    end else begin
      wr_stb       <= 1'b0;
      rd_req       <= 1'b0;
      err_cmd      <= 1'b0;
      err_underrun <= 1'b0;

      if (rd_vld && pending) begin
        rbuf     <= rd_data;
        rbuf_vld <= 1'b1;
        pending  <= 1'b0;
      end

      if (state == IDLE || abort) begin
        bit_cnt  <= '0;
        tx_cnt   <= '0;
        miso     <= 1'b1;
        rbuf_vld <= 1'b0;
        pending  <= 1'b0;
      end
      if (state == IDLE && state_nxt == CMD) word_cnt <= 8'd0;

      if (sclk_rise && !abort &&
          (state == CMD || state == ADDR || state == WR_DATA || state == RD_DATA)) begin
        rx_sh   <= rx_next;
        bit_cnt <= (cmd_last || addr_last || data_last) ? '0 : bit_cnt + CNT_W'(1);
      end

      if (cmd_last) begin
        is_rd   <= op_rd;
        err_cmd <= !(op_wr || op_rd);
      end

      if (addr_last) begin
        if (is_rd) begin
          rd_addr <= rx_next[ADDR_W-1:0];
          rd_req  <= 1'b1;
          pending <= 1'b1;
          ptr     <= rx_next[ADDR_W-1:0] + ADDR_W'(ADDR_INC);
        end else begin
          ptr     <= rx_next[ADDR_W-1:0];
        end
      end

      if (data_last) begin
        if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
        if (state == WR_DATA) begin
          wr_stb  <= 1'b1;
          wr_data <= rx_next[DATA_W-1:0];
          wr_addr <= ptr;
          ptr     <= ptr + ADDR_W'(ADDR_INC);
        end
      end

      // the MSB launch of each word also fires the prefetch of the next one
      if (state == RD_DATA && sclk_fall && !abort) begin
        if (launch) begin
          rd_addr  <= ptr;
          rd_req   <= 1'b1;
          pending  <= 1'b1;
          ptr      <= ptr + ADDR_W'(ADDR_INC);
          rbuf_vld <= 1'b0;
          if (rbuf_vld) begin
            tx_sh <= rbuf;
            miso  <= rbuf[DATA_W-1];
          end else begin
            tx_sh        <= '1;
            miso         <= 1'b1;
            err_underrun <= 1'b1;
          end
        end else begin
          miso  <= tx_sh[DATA_W-2];
          tx_sh <= tx_sh << 1;
        end
        tx_cnt <= (tx_cnt == CNT_W'(DATA_W - 1)) ? '0 : tx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Scoreboard bench for spi_slave_burst: a bit-banged SPI master drives
// directed frames; expected writes, read requests and miso words are queued.
`timescale 1ns/1ps
module tb_spi_slave_burst;
  localparam int HALF = 80;

  logic        clk_100m = 1'b0;
  logic        rst_n_syn = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data = 32'h0;
  logic        wr_stb, rd_req, busy, err_cmd, err_underrun;
  logic        rd_vld = 1'b0;
  logic [7:0]  word_cnt;

  always #5 clk_100m = ~clk_100m;

  spi_slave_burst dut (
    .clk_100m(clk_100m), .rst_n_syn(rst_n_syn), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_stb(wr_stb), .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data),
    .rd_vld(rd_vld), .busy(busy), .err_cmd(err_cmd),
    .err_underrun(err_underrun), .word_cnt(word_cnt)
  );

  typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;

  int          checks = 0, failures = 0;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [31:0] exp_miso[$];
  bit          tx_bits[$];
  int          err_cmd_seen = 0, underrun_seen = 0;
  int          req_in_frame = 0, withhold_idx = -1, miso_low_seen = 0;
  int          resp_idx;
  logic [15:0] resp_a;
  logic        exp_busy = 1'b1;
  wr_t         got_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s unexpected event, actual=0x%0h required=none", name, act);
  endtask

  // monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk_100m) begin
    if (rst_n_syn) begin
      if (wr_stb) begin
        got_wr = {wr_addr, wr_data};
        if (exp_wr.size() == 0) fail_evt("wr_stb", 64'(got_wr));
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.a));
          chk("wr_data", 64'(wr_data), 64'(e.d));
        end
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) fail_evt("rd_req", 64'(rd_addr));
        else chk("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
      end
      if (err_cmd)      err_cmd_seen++;
      if (err_underrun) underrun_seen++;
    end
  end

  // read responder: returns {addr, ~addr} one cycle after each request
  initial forever begin
    @(negedge clk_100m);
    if (rd_req) begin
      resp_idx = req_in_frame;
      req_in_frame++;
      resp_a = rd_addr;
      if (resp_idx != withhold_idx) begin
        @(posedge clk_100m); #1;
        rd_data = {resp_a, ~resp_a};
        rd_vld  = 1'b1;
        @(posedge clk_100m); #1;
        rd_vld  = 1'b0;
      end
    end
  end

  task automatic push_bits(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) tx_bits.push_back(v[i]);
  endtask

  task automatic spi_frame(input int rx_from, input bit check_ones);
    int nrx;
    logic [31:0] rxw;
    nrx = 0;
    rxw = '0;
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < tx_bits.size(); i++) begin
      sclk = 1'b0;
      mosi = tx_bits[i];
      #HALF;
      if (i == 8) chk("busy", 64'(busy), 64'(exp_busy));
      if (check_ones && miso !== 1'b1) miso_low_seen++;
      if (rx_from >= 0 && i >= rx_from) begin
        rxw = {rxw[30:0], miso};
        nrx++;
        if (nrx == 32) begin
          nrx = 0;
          if (exp_miso.size() == 0) fail_evt("miso_word", 64'(rxw));
          else chk("miso_word", 64'(rxw), 64'(exp_miso.pop_front()));
        end
      end
      sclk = 1'b1;
      #HALF;
    end
    cs_n = 1'b1;
    #HALF;
    sclk = 1'b0;
    mosi = 1'b0;
    #(4 * HALF);
    tx_bits.delete();
  endtask

  task automatic end_check(input string tag, input int e_cmd, input int e_und, input int e_wc);
    #200;
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
    chk({tag, "_miso_left"}, 64'(exp_miso.size()), 64'd0);
    chk({tag, "_err_cmd"}, 64'(err_cmd_seen), 64'(e_cmd));
    chk({tag, "_underrun"}, 64'(underrun_seen), 64'(e_und));
    chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(e_wc));
    exp_wr.delete(); exp_rd.delete(); exp_miso.delete();
    err_cmd_seen = 0; underrun_seen = 0; req_in_frame = 0; withhold_idx = -1;
  endtask

  initial begin
    #23;
    chk("rst_miso", 64'(miso), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_outs", 64'({wr_addr, rd_addr, wr_stb, rd_req, err_cmd, err_underrun}), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    #20 rst_n_syn = 1'b1;
    #100;

    push_bits(32'h0A, 8); push_bits(32'h0010, 16); push_bits(32'hDEADBEEF, 32);
    exp_wr.push_back({16'h0010, 32'hDEADBEEF});
    spi_frame(-1, 1'b0);
    end_check("wr1", 0, 0, 1);

    push_bits(32'h0A, 8); push_bits(32'hFFFF, 16);
    push_bits(32'h11111111, 32); push_bits(32'h22222222, 32); push_bits(32'h33333333, 32);
    exp_wr.push_back({16'hFFFF, 32'h11111111});
    exp_wr.push_back({16'h0000, 32'h22222222});
    exp_wr.push_back({16'h0001, 32'h33333333});
    spi_frame(-1, 1'b0);
    end_check("wrap", 0, 0, 3);

    // base request plus one prefetch per launched word
    push_bits(32'h0F, 8); push_bits(32'h0100, 16);
    for (int k = 0; k < 3; k++) push_bits(32'h0, 32);
    exp_rd.push_back(16'h0100); exp_rd.push_back(16'h0101);
    exp_rd.push_back(16'h0102); exp_rd.push_back(16'h0103);
    exp_miso.push_back(32'h0100FEFF); exp_miso.push_back(32'h0101FEFE);
    exp_miso.push_back(32'h0102FEFD);
    spi_frame(24, 1'b0);
    end_check("rd", 0, 0, 3);

    withhold_idx = 1;
    push_bits(32'h0F, 8); push_bits(32'h0200, 16);
    for (int k = 0; k < 3; k++) push_bits(32'h0, 32);
    exp_rd.push_back(16'h0200); exp_rd.push_back(16'h0201);
    exp_rd.push_back(16'h0202); exp_rd.push_back(16'h0203);
    exp_miso.push_back(32'h0200FDFF); exp_miso.push_back(32'hFFFFFFFF);
    exp_miso.push_back(32'h0202FDFD);
    spi_frame(24, 1'b0);
    end_check("und", 0, 1, 3);

    push_bits(32'h0A, 8); push_bits(32'h0030, 16); push_bits(32'h1FFFF, 17);
    spi_frame(-1, 1'b0);
    end_check("abort", 0, 0, 0);

    push_bits(32'h0A, 8); push_bits(32'h0040, 16); push_bits(32'h12345678, 32);
    exp_wr.push_back({16'h0040, 32'h12345678});
    spi_frame(-1, 1'b0);
    end_check("recover", 0, 0, 1);

    miso_low_seen = 0;
    push_bits(32'h55, 8); push_bits(32'h0A00, 16); push_bits(32'h0F0F0F0F, 32);
    spi_frame(-1, 1'b1);
    chk("badop_miso_low", 64'(miso_low_seen), 64'd0);
    end_check("badop", 1, 0, 0);

    // reset released mid-frame: the rest of that frame must be ignored
    cs_n = 1'b0;
    #100;
    rst_n_syn = 1'b0;
    #30;
    rst_n_syn = 1'b1;
    #50;
    exp_busy = 1'b0;
    push_bits(32'h0A, 8); push_bits(32'h0060, 16); push_bits(32'hA5A5A5A5, 32);
    spi_frame(-1, 1'b0);
    end_check("rstmid", 0, 0, 0);

    exp_busy = 1'b1;
    push_bits(32'h0A, 8); push_bits(32'h0050, 16); push_bits(32'hCAFEF00D, 32);
    exp_wr.push_back({16'h0050, 32'hCAFEF00D});
    spi_frame(-1, 1'b0);
    end_check("post_rst", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
